// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// default widths for the accumulator and beat-count fields.
package product_accumulator_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Run-control, operand and result handshake bundle of the product accumulator.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             busy;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/fourbit_multiplier.sv
// Unsigned 4x4 -> 8 bit combinational multiplier built from shifted
// partial products.
module fourbit_multiplier (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_pp0;
  logic [7:0] w_pp1;
  logic [7:0] w_pp2;
  logic [7:0] w_pp3;

  assign w_pp0 = {4'b0000, i_a & {4{i_b[0]}}};
  assign w_pp1 = {3'b000,  i_a & {4{i_b[1]}}, 1'b0};
  assign w_pp2 = {2'b00,   i_a & {4{i_b[2]}}, 2'b00};
  assign w_pp3 = {1'b0,    i_a & {4{i_b[3]}}, 3'b000};
  assign o_p   = w_pp0 + w_pp1 + w_pp2 + w_pp3;
endmodule

// File: rtl/product_accumulator.sv
// Accumulates a*b over a run of len beats (0 means 2**LEN_W), then presents
// the sum with a valid/ready handshake. Products are registered one stage
// (prod_r) before being added, so a FLUSH cycle drains the final product.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  product_accumulator_if.slave bus
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W:0]   r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_prod;
  logic             r_prod_v;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_busy_nxt;
  logic [7:0]       w_prod;
  logic             w_accept;
  logic             w_last;
  logic [LEN_W:0]   w_len_cnt;

  fourbit_multiplier u_mul (
    .i_a (bus.a),
    .i_b (bus.b),
    .o_p (w_prod)
  );

  // in_ready is registered from the next state, so it equals (state == ACCUM)
  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_last    = w_accept & (r_cnt == {{LEN_W{1'b0}}, 1'b1});
  assign w_len_cnt = (bus.len == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}}
                                                 : {1'b0, bus.len};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; DONE is left only once the consumer has seen out_valid
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ACCUM; else w_state_nxt = IDLE;
      ACCUM:   if (w_last) w_state_nxt = FLUSH; else w_state_nxt = ACCUM;
      FLUSH:   w_state_nxt = DONE;
      DONE:    if (r_out_valid && bus.out_ready) w_state_nxt = IDLE;
               else w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode; out_valid rises one cycle into DONE and drops on handshake
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == ACCUM);
    w_busy_nxt      = (w_state_nxt != IDLE);
    w_out_valid_nxt = 1'b0;
    if (r_state == DONE) begin
      w_out_valid_nxt = !(r_out_valid && bus.out_ready);
    end else begin
      w_out_valid_nxt = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Datapath: beat counter, product stage and accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= {(LEN_W+1){1'b0}};
      r_acc    <= {ACC_W{1'b0}};
      r_prod   <= 8'd0;
      r_prod_v <= 1'b0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_cnt    <= w_len_cnt;
      r_acc    <= {ACC_W{1'b0}};
      r_prod_v <= 1'b0;
    end else begin
      if (w_accept) begin
        r_prod   <= w_prod;
        r_prod_v <= 1'b1;
        r_cnt    <= r_cnt - {{LEN_W{1'b0}}, 1'b1};
      end else begin
        r_prod_v <= 1'b0;
      end
      if (r_prod_v) begin
        r_acc <= r_acc + {{(ACC_W-8){1'b0}}, r_prod};
      end else begin
        r_acc <= r_acc;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.sum       = r_acc;
endmodule

// File: tb/tb_product_accumulator.sv
// Scenario bench for product_accumulator: expected sums are pushed to a
// scoreboard as beats are driven and popped when out_valid appears.
module tb_product_accumulator;
  localparam int ACC_W = 12;
  localparam int LEN_W = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   sb[$];

  product_accumulator_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) ifc ();

  product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int len);
    ifc.start = 1'b1;
    ifc.len   = len[LEN_W-1:0];
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic drive_beat(input int av, input int bv, inout int model);
    ifc.in_valid = 1'b1;
    ifc.a        = av[3:0];
    ifc.b        = bv[3:0];
    tick();
    ifc.in_valid = 1'b0;
    model        = model + av * bv;
  endtask

  task automatic wait_out(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (ifc.out_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic release_out();
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if ({ifc.in_ready, ifc.out_valid, ifc.busy} !== 3'b000 || ifc.sum !== 12'd0) begin
      $display("FAIL reset_outputs: got rdy/vld/busy=%b sum=%0d, want 000 sum=0",
               {ifc.in_ready, ifc.out_valid, ifc.busy}, ifc.sum);
    end else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++;
    if ({ifc.in_ready, ifc.out_valid, ifc.busy} !== 3'b000 || ifc.sum !== 12'd0) begin
      $display("FAIL after_reset: got rdy/vld/busy=%b sum=%0d, want 000 sum=0",
               {ifc.in_ready, ifc.out_valid, ifc.busy}, ifc.sum);
    end else n_pass++;
  endtask

  task automatic test_single_run();
    int model = 0;
    int exp;
    start_run(3);
    n_total++;
    if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b1) begin
      $display("FAIL accum_ready: got in_ready=%b busy=%b, want 1 1", ifc.in_ready, ifc.busy);
    end else n_pass++;
    drive_beat(3, 5, model);
    drive_beat(15, 15, model);
    drive_beat(0, 9, model);   // this is edge k
    sb.push_back(model);
    tick();                    // k+1
    tick();                    // k+2
    exp = sb.pop_front();
    n_total++;
    if (ifc.out_valid !== 1'b1 || ifc.sum !== exp[ACC_W-1:0]) begin
      $display("FAIL single_latency: got out_valid=%b sum=%0d, want 1 sum=%0d",
               ifc.out_valid, ifc.sum, exp);
    end else n_pass++;
    n_total++;
    if (ifc.in_ready !== 1'b0) begin
      $display("FAIL done_not_ready: got in_ready=%b, want 0", ifc.in_ready);
    end else n_pass++;
    release_out();
    n_total++;
    if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      $display("FAIL single_release: got out_valid=%b busy=%b, want 0 0", ifc.out_valid, ifc.busy);
    end else n_pass++;
  endtask

  task automatic test_max();
    int model = 0;
    int exp;
    int busy_low = 0;
    bit to;
    start_run(0);
    for (int i = 0; i < 16; i++) begin
      if (ifc.busy !== 1'b1) busy_low++;
      drive_beat(15, 15, model);
    end
    sb.push_back(model);
    for (int i = 0; i < 40; i++) begin
      if (ifc.out_valid === 1'b1) break;
      if (ifc.busy !== 1'b1) busy_low++;
      tick();
    end
    wait_out(to);
    exp = sb.pop_front();
    n_total++;
    if (to || ifc.sum !== exp[ACC_W-1:0]) begin
      $display("FAIL max_sum: got timeout=%0d sum=%0d, want sum=%0d", to, ifc.sum, exp);
    end else n_pass++;
    n_total++;
    if (busy_low != 0) begin
      $display("FAIL max_busy: got %0d cycles with busy low, want 0", busy_low);
    end else n_pass++;
    release_out();
  endtask

  task automatic test_stall();
    int model = 0;
    int exp;
    bit to;
    start_run(2);
    drive_beat(2, 3, model);
    for (int i = 0; i < 4; i++) tick();
    n_total++;
    if (ifc.sum !== 12'd6 || ifc.in_ready !== 1'b1) begin
      $display("FAIL stall_hold: got sum=%0d in_ready=%b, want 6 1", ifc.sum, ifc.in_ready);
    end else n_pass++;
    drive_beat(4, 4, model);
    sb.push_back(model);
    wait_out(to);
    exp = sb.pop_front();
    n_total++;
    if (to || ifc.sum !== exp[ACC_W-1:0]) begin
      $display("FAIL stall_sum: got timeout=%0d sum=%0d, want sum=%0d", to, ifc.sum, exp);
    end else n_pass++;
    release_out();
  endtask

  task automatic test_backpressure();
    int model = 0;
    int exp;
    int unstable = 0;
    bit to;
    start_run(1);
    drive_beat(5, 5, model);
    sb.push_back(model);
    wait_out(to);
    exp = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      ifc.start = 1'b1;
      ifc.len   = 4'd2;
      tick();
      if (ifc.out_valid !== 1'b1 || ifc.sum !== exp[ACC_W-1:0] || ifc.busy !== 1'b1) unstable++;
    end
    ifc.start = 1'b0;
    n_total++;
    if (to || unstable != 0) begin
      $display("FAIL bp_stable: got timeout=%0d unstable_cycles=%0d, want 0 0", to, unstable);
    end else n_pass++;
    release_out();
    tick();
    n_total++;
    if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.in_ready !== 1'b0) begin
      $display("FAIL bp_idle: got vld=%b busy=%b rdy=%b, want 0 0 0",
               ifc.out_valid, ifc.busy, ifc.in_ready);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int model = 0;
    int exp;
    bit to;
    start_run(4);
    drive_beat(7, 7, model);
    drive_beat(7, 7, model);
    rst_n = 1'b0;
    tick();
    n_total++;
    if ({ifc.in_ready, ifc.out_valid, ifc.busy} !== 3'b000 || ifc.sum !== 12'd0) begin
      $display("FAIL midrun_reset: got rdy/vld/busy=%b sum=%0d, want 000 sum=0",
               {ifc.in_ready, ifc.out_valid, ifc.busy}, ifc.sum);
    end else n_pass++;
    rst_n = 1'b1;
    model = 0;
    start_run(1);
    drive_beat(1, 1, model);
    sb.push_back(model);
    wait_out(to);
    exp = sb.pop_front();
    n_total++;
    if (to || ifc.sum !== exp[ACC_W-1:0]) begin
      $display("FAIL post_reset_sum: got timeout=%0d sum=%0d, want sum=%0d", to, ifc.sum, exp);
    end else n_pass++;
    release_out();
  endtask

  task automatic test_back_to_back();
    int model = 0;
    int exp;
    bit to;
    start_run(1);
    drive_beat(3, 3, model);
    sb.push_back(model);
    wait_out(to);
    exp = sb.pop_front();
    n_total++;
    if (to || ifc.sum !== exp[ACC_W-1:0]) begin
      $display("FAIL b2b_first: got timeout=%0d sum=%0d, want sum=%0d", to, ifc.sum, exp);
    end else n_pass++;
    release_out();
    model = 0;
    start_run(1);
    drive_beat(2, 2, model);
    sb.push_back(model);
    wait_out(to);
    exp = sb.pop_front();
    n_total++;
    if (to || ifc.sum !== exp[ACC_W-1:0]) begin
      $display("FAIL b2b_second: got timeout=%0d sum=%0d, want sum=%0d", to, ifc.sum, exp);
    end else n_pass++;
    release_out();
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    ifc.start     = 1'b0;
    ifc.len       = 4'd0;
    ifc.in_valid  = 1'b0;
    ifc.a         = 4'd0;
    ifc.b         = 4'd0;
    ifc.out_ready = 1'b0;
    test_reset();
    test_single_run();
    test_max();
    test_stall();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
